// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_sequencer
// Purpose  : Streams one frame of NUM_LEDS 24-bit GRB pixels from the
//            displayed half of a double-buffered pixel memory to a serial
//            bit encoder, then holds the line in the latch (reset) gap.
//            The host swaps buffers with frame_commit; a swap only takes
//            effect at the start of a frame.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   permits new frames to start
//   frame_commit in   one-cycle pulse, back buffer is complete
//   mem_rd       out  one-cycle read strobe to pixel memory
//   mem_addr     out  read address = buf_sel*NUM_LEDS + pixel index
//   mem_rdata    in   pixel read data, valid one cycle after mem_rd
//   pix_valid    out  pixel offered to the encoder
//   pix_data     out  offered pixel
//   pix_ready    in   encoder accepts when pix_valid && pix_ready
//   latch        out  high during the latch gap
//   buf_sel      out  front (displayed) buffer
//   busy         out  high whenever not idle
//   frame_done   out  one-cycle pulse after each frame's latch gap
//   frame_count  out  completed frames, wraps at 16 bits
// ============================================================================
module led_frame_sequencer #(
  parameter int NUM_LEDS     = 160,
  parameter int RESET_CYCLES = 50000,
  parameter int AW           = $clog2(2 * NUM_LEDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          frame_commit,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [23:0]   mem_rdata,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  input  logic          pix_ready,
  output logic          latch,
  output logic          buf_sel,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int GAP_W = $clog2(RESET_CYCLES) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);
  localparam logic [AW-1:0]    BUF_BASE = AW'(NUM_LEDS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_LATCH   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_next_idx;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   w_next_gap;
  logic               r_commit_pending;
  logic               w_next_pending;
  logic               w_next_buf_sel;
  logic               w_next_pix_valid;
  logic [23:0]        w_next_pix_data;
  logic               w_next_frame_done;
  logic [15:0]        w_next_frame_count;

  // State and datapath registers. Everything the host can see is cleared
  // asynchronously so a mid-frame reset drops the frame on the spot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_idx            <= '0;
      r_gap            <= '0;
      r_commit_pending <= 1'b0;
      buf_sel          <= 1'b0;
      pix_valid        <= 1'b0;
      pix_data         <= '0;
      frame_done       <= 1'b0;
      frame_count      <= '0;
    end else begin
      r_state          <= w_next_state;
      r_idx            <= w_next_idx;
      r_gap            <= w_next_gap;
      r_commit_pending <= w_next_pending;
      buf_sel          <= w_next_buf_sel;
      pix_valid        <= w_next_pix_valid;
      pix_data         <= w_next_pix_data;
      frame_done       <= w_next_frame_done;
      frame_count      <= w_next_frame_count;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next_state       = r_state;
    w_next_idx         = r_idx;
    w_next_gap         = r_gap;
    // Commits arriving at any time fold into one pending swap.
    w_next_pending     = r_commit_pending | frame_commit;
    w_next_buf_sel     = buf_sel;
    w_next_pix_valid   = pix_valid;
    w_next_pix_data    = pix_data;
    w_next_frame_done  = 1'b0;
    w_next_frame_count = frame_count;

    mem_rd   = (r_state == ST_FETCH);
    latch    = (r_state == ST_LATCH);
    busy     = (r_state != ST_IDLE);
    mem_addr = AW'(r_idx) + (buf_sel ? BUF_BASE : '0);

    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_next_state = ST_FETCH;
          w_next_idx   = '0;
          // The only place the front buffer may change, so a frame is
          // always read entirely from one buffer. A commit landing in this
          // very cycle is honoured rather than deferred a whole frame.
          if (r_commit_pending || frame_commit) begin
            w_next_buf_sel = ~buf_sel;
            w_next_pending = 1'b0;
          end
        end
      end

      ST_FETCH: begin
        w_next_state = ST_WAIT;
      end

      ST_WAIT: begin
        // Memory data is valid now, one cycle after the strobe.
        w_next_pix_data  = mem_rdata;
        w_next_pix_valid = 1'b1;
        w_next_state     = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (pix_ready) begin
          w_next_pix_valid = 1'b0;
          if (r_idx == IDX_LAST) begin
            w_next_gap   = '0;
            w_next_state = ST_LATCH;
          end else begin
            w_next_idx   = r_idx + IDX_W'(1);
            w_next_state = ST_FETCH;
          end
        end
      end

      ST_LATCH: begin
        if (r_gap == GAP_LAST) begin
          w_next_state       = ST_IDLE;
          w_next_frame_done  = 1'b1;
          w_next_frame_count = frame_count + 16'd1;
        end else begin
          w_next_gap = r_gap + GAP_W'(1);
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_sequencer
// Purpose  : Self-checking bench for led_frame_sequencer with NUM_LEDS=4 and
//            RESET_CYCLES=10. The pixel memory returns its own address as
//            data. A negedge monitor records reads, handshakes, latch runs
//            and frame_done pulses; each scenario compares those records
//            against a frame-level model (expected buffer per frame).
// Revision : 1.0  initial release
// ============================================================================
module tb_led_frame_sequencer;

  localparam int N  = 4;
  localparam int RC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_commit = 1'b0;
  logic        mem_rd;
  logic [2:0]  mem_addr;
  logic [23:0] mem_rdata = '0;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready = 1'b0;
  logic        latch;
  logic        buf_sel;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  int rd_q[$];
  int bs_q[$];
  int cyc_q[$];
  int hs_q[$];
  int latch_q[$];
  int exp_q[$];
  int done_cnt = 0;
  int lat_run = 0;
  int viol = 0;
  int cyc = 0;

  led_frame_sequencer #(
    .NUM_LEDS    (N),
    .RESET_CYCLES(RC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_commit(frame_commit),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .latch       (latch),
    .buf_sel     (buf_sel),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Pixel memory: data = 24'h0000 followed by the address, one cycle late.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= {21'd0, mem_addr};
  end

  // Event recorder.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      lat_run = 0;
    end else begin
      if (mem_rd) begin
        rd_q.push_back(int'(mem_addr));
        bs_q.push_back(int'(buf_sel));
        cyc_q.push_back(cyc);
      end
      if (pix_valid && pix_ready) hs_q.push_back(int'(pix_data));
      if (latch) lat_run++;
      else if (lat_run > 0) begin
        latch_q.push_back(lat_run);
        lat_run = 0;
      end
      if (frame_done) done_cnt++;
      if (latch && pix_valid) viol++;
      if (mem_rd && pix_valid) viol++;
    end
  end

  // Model: expected address sequence for nfr frames starting from buffer 0;
  // bit k of swap_mask means a commit was made during frame k.
  task automatic build_expected(input int nfr, input int swap_mask);
    int b;
    b = 0;
    exp_q.delete();
    for (int k = 0; k < nfr; k++) begin
      for (int i = 0; i < N; i++) exp_q.push_back(b * N + i);
      if (swap_mask[k]) b = 1 - b;
    end
  endtask

  task automatic clear_records();
    rd_q.delete(); bs_q.delete(); cyc_q.delete(); hs_q.delete();
    latch_q.delete(); done_cnt = 0; viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; frame_commit = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    clear_records();
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n;
    n = 0;
    while (rd_q.size() < target && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (rd_q.size() < target) begin
      errors++;
      $display("FAIL %s read timeout: reads=%0d required=%0d", tag, rd_q.size(), target);
    end
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s frame timeout: done=%0d required=%0d", tag, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (pix_valid !== 1'b0)  begin errors++; $display("FAIL rst pix_valid got=%b exp=0", pix_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst busy got=%b exp=0", busy); end
    checks++; if (mem_rd !== 1'b0)     begin errors++; $display("FAIL rst mem_rd got=%b exp=0", mem_rd); end
    checks++; if (mem_addr !== 3'd0)   begin errors++; $display("FAIL rst mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (latch !== 1'b0)      begin errors++; $display("FAIL rst latch got=%b exp=0", latch); end
    checks++; if (buf_sel !== 1'b0)    begin errors++; $display("FAIL rst buf_sel got=%b exp=0", buf_sel); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst frame_done got=%b exp=0", frame_done); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst frame_count got=%0d exp=0", frame_count); end
    checks++; if (pix_data !== 24'd0)  begin errors++; $display("FAIL rst pix_data got=%h exp=0", pix_data); end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    enable = 1'b1; pix_ready = 1'b1;
    n = 0;
    while (!latch && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1 enable = 1'b0;
    wait_done(1, "basic");
    repeat (5) @(negedge clk);
    #1;
    build_expected(1, 0);
    checks++; if (rd_q.size() !== N) begin errors++; $display("FAIL basic nreads got=%0d exp=%0d", rd_q.size(), N); end
    for (int i = 0; i < N && i < rd_q.size() && i < hs_q.size(); i++) begin
      checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic addr[%0d] got=%0d exp=%0d", i, rd_q[i], exp_q[i]); end
      checks++; if (hs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic data[%0d] got=%0d exp=%0d", i, hs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < cyc_q.size(); i++) begin
      checks++; if (cyc_q[i] - cyc_q[i-1] !== 3) begin errors++; $display("FAIL basic period[%0d] got=%0d exp=3", i, cyc_q[i] - cyc_q[i-1]); end
    end
    checks++; if (latch_q.size() !== 1 || latch_q[0] !== RC) begin errors++; $display("FAIL basic latch_len got=%0d runs first=%0d exp=1 run of %0d", latch_q.size(), (latch_q.size() > 0) ? latch_q[0] : -1, RC); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic frame_count got=%0d exp=1", frame_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_commit();
    int n;
    do_reset();
    enable = 1'b1; pix_ready = 1'b1;
    wait_rd(2, "commit");
    @(posedge clk); #1 frame_commit = 1'b1;
    @(posedge clk); #1 frame_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1 frame_commit = 1'b1;
    @(posedge clk); #1 frame_commit = 1'b0;
    n = 0;
    while (!latch && n < 100) begin @(negedge clk); #1; n++; end
    checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL commit buf_in_latch got=%b exp=0", buf_sel); end
    wait_rd(2 * N + 1, "commit");
    @(posedge clk); #1 enable = 1'b0;
    wait_done(3, "commit");
    build_expected(3, 1);
    checks++; if (rd_q.size() !== 3 * N) begin errors++; $display("FAIL commit nreads got=%0d exp=%0d", rd_q.size(), 3 * N); end
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
      checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL commit addr[%0d] got=%0d exp=%0d", i, rd_q[i], exp_q[i]); end
      checks++; if (bs_q[i] !== exp_q[i] / N) begin errors++; $display("FAIL commit buf_sel[%0d] got=%0d exp=%0d", i, bs_q[i], exp_q[i] / N); end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL commit frame_count got=%0d exp=3", frame_count); end
  endtask

  task automatic test_stall();
    do_reset();
    enable = 1'b1; pix_ready = 1'b1;
    wait_rd(3, "stall");
    @(posedge clk); #1 pix_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL stall valid[%0d] got=%b exp=1", i, pix_valid); end
      checks++; if (pix_data !== 24'd2) begin errors++; $display("FAIL stall data[%0d] got=%h exp=000002", i, pix_data); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL stall mem_rd[%0d] got=%b exp=0", i, mem_rd); end
    end
    @(posedge clk); #1 pix_ready = 1'b1; enable = 1'b0;
    @(negedge clk); #1;
    checks++; if (hs_q.size() !== 3) begin errors++; $display("FAIL stall handshakes got=%0d exp=3", hs_q.size()); end
    @(negedge clk); #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 3'd3) begin errors++; $display("FAIL stall next_fetch got rd=%b addr=%0d exp rd=1 addr=3", mem_rd, mem_addr); end
    wait_done(1, "stall");
    build_expected(1, 0);
    for (int i = 0; i < N && i < hs_q.size(); i++) begin
      checks++; if (hs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall data_seq[%0d] got=%0d exp=%0d", i, hs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1; pix_ready = 1'b1;
    wait_rd(2, "endrop");
    @(posedge clk); #1 enable = 1'b0;
    wait_done(1, "endrop");
    repeat (20) @(negedge clk);
    #1;
    build_expected(1, 0);
    checks++; if (rd_q.size() !== N) begin errors++; $display("FAIL endrop nreads got=%0d exp=%0d", rd_q.size(), N); end
    for (int i = 0; i < N && i < hs_q.size(); i++) begin
      checks++; if (hs_q[i] !== exp_q[i]) begin errors++; $display("FAIL endrop data[%0d] got=%0d exp=%0d", i, hs_q[i], exp_q[i]); end
    end
    checks++; if (latch_q.size() !== 1 || latch_q[0] !== RC) begin errors++; $display("FAIL endrop latch runs=%0d exp 1 run of %0d", latch_q.size(), RC); end
    checks++; if (busy !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL endrop idle got busy=%b done=%0d exp busy=0 done=1", busy, done_cnt); end
  endtask

  task automatic test_commit_same_cycle();
    do_reset();
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1; frame_commit = 1'b1;
    @(posedge clk); #1 frame_commit = 1'b0;
    @(negedge clk); #1;
    checks++; if (buf_sel !== 1'b1 || mem_addr !== 3'd4) begin errors++; $display("FAIL samecyc swap got buf=%b addr=%0d exp buf=1 addr=4", buf_sel, mem_addr); end
    wait_rd(N + 1, "samecyc");
    @(posedge clk); #1 enable = 1'b0;
    wait_done(2, "samecyc");
    checks++; if (rd_q.size() !== 2 * N) begin errors++; $display("FAIL samecyc nreads got=%0d exp=%0d", rd_q.size(), 2 * N); end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++; if (rd_q[i] !== N + (i % N)) begin errors++; $display("FAIL samecyc addr[%0d] got=%0d exp=%0d", i, rd_q[i], N + (i % N)); end
    end
  endtask

  task automatic test_random();
    int ncommit[4];
    int issued[4];
    int n, cur, k, p, mask;
    bit last;
    do_reset();
    mask = 0;
    for (int i = 0; i < 4; i++) begin
      ncommit[i] = int'($urandom_range(0, 2));
      issued[i] = 0;
      if (ncommit[i] > 0) mask = mask | (1 << i);
    end
    enable = 1'b1;
    last = 1'b0;
    n = 0;
    while (done_cnt < 4 && n < 1500) begin
      @(posedge clk); #1;
      pix_ready = 1'($urandom_range(0, 1));
      frame_commit = 1'b0;
      cur = rd_q.size();
      if (cur >= 1) begin
        k = (cur - 1) / N;
        p = (cur - 1) % N;
        if (k < 4 && p >= 1 && p <= 2 && issued[k] < ncommit[k] && !last) begin
          frame_commit = 1'b1;
          issued[k]++;
        end
      end
      last = frame_commit;
      if (cur >= 3 * N + 1) enable = 1'b0;
      n++;
    end
    frame_commit = 1'b0;
    checks++; if (done_cnt !== 4) begin errors++; $display("FAIL rand frames got=%0d exp=4", done_cnt); end
    build_expected(4, mask);
    checks++; if (rd_q.size() !== 4 * N) begin errors++; $display("FAIL rand nreads got=%0d exp=%0d", rd_q.size(), 4 * N); end
    for (int i = 0; i < exp_q.size() && i < rd_q.size() && i < hs_q.size(); i++) begin
      checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand addr[%0d] got=%0d exp=%0d", i, rd_q[i], exp_q[i]); end
      checks++; if (hs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand data[%0d] got=%0d exp=%0d", i, hs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < latch_q.size(); i++) begin
      checks++; if (latch_q[i] !== RC) begin errors++; $display("FAIL rand latch[%0d] got=%0d exp=%0d", i, latch_q[i], RC); end
    end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL rand frame_count got=%0d exp=4", frame_count); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    enable = 1'b1; pix_ready = 1'b1;
    wait_rd(2, "areset");
    @(posedge clk); #1 frame_commit = 1'b1;
    @(posedge clk); #1 frame_commit = 1'b0;
    wait_done(1, "areset");
    @(posedge clk); #1 pix_ready = 1'b0;
    n = 0;
    while (!pix_valid && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (pix_valid !== 1'b1 || busy !== 1'b1 || buf_sel !== 1'b1 || frame_count !== 16'd1) begin
      errors++; $display("FAIL areset pre got valid=%b busy=%b buf=%b cnt=%0d exp 1 1 1 1", pix_valid, busy, buf_sel, frame_count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL areset pix_valid got=%b exp=0", pix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset busy got=%b exp=0", busy); end
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL areset latch got=%b exp=0", latch); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL areset frame_count got=%0d exp=0", frame_count); end
    checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL areset buf_sel got=%b exp=0", buf_sel); end
    repeat (2) @(posedge clk);
    clear_records();
    #1 rst_n = 1'b1; pix_ready = 1'b1; enable = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || buf_sel !== 1'b0) begin errors++; $display("FAIL areset restart got busy=%b buf=%b exp 0 0", busy, buf_sel); end
    wait_rd(1, "areset");
    @(posedge clk); #1 enable = 1'b0;
    wait_done(1, "areset");
    build_expected(1, 0);
    for (int i = 0; i < N && i < rd_q.size(); i++) begin
      checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL areset addr[%0d] got=%0d exp=%0d", i, rd_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_invariants();
    checks++; if (viol !== 0) begin errors++; $display("FAIL invariants overlap_cycles got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_commit();
    test_stall();
    test_enable_drop();
    test_commit_same_cycle();
    test_random();
    test_async_reset();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 160, giving the number of pixels per frame.
REQ-002 The block SHALL have parameter RESET_CYCLES, default 50000, giving the latch (reset-gap) length in clk cycles.
REQ-003 The block SHALL have parameter AW, default $clog2(2*NUM_LEDS), giving the frame-memory address width.
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; permits new frames to start.
- frame_commit  in  1  one-cycle pulse; host has finished writing the back buffer.
- mem_rd  out  1  one-cycle read strobe to the double-buffered pixel memory.
- mem_addr  out  AW  read address, equal to buf_sel*NUM_LEDS + pixel index.
- mem_rdata  in  24  GRB pixel; valid exactly one cycle after mem_rd.
- pix_valid  out  1  pixel offered to the bit encoder.
- pix_data  out  24  offered pixel.
- pix_ready  in  1  encoder accepts the pixel when pix_valid && pix_ready.
- latch  out  1  high throughout the reset gap; the encoder holds its line low.
- buf_sel  out  1  buffer currently displayed (front buffer).
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_count  out  16  number of completed frames.

Function
REQ-005 The FSM SHALL have five states: IDLE, FETCH, WAIT, PRESENT and LATCH.
REQ-006 In IDLE with enable=1, the block SHALL perform the buffer-swap check (REQ-012), clear the pixel index to 0, and go to FETCH on the next cycle.
REQ-007 In IDLE with enable=0, the block SHALL remain in IDLE.
REQ-008 FETCH SHALL assert mem_rd for exactly one cycle, with mem_addr = buf_sel*NUM_LEDS + idx, and then go to WAIT.
REQ-009 WAIT SHALL register mem_rdata into pix_data, assert pix_valid, and go to PRESENT.
REQ-010 In PRESENT, pix_valid and pix_data SHALL stay constant until the cycle in which pix_ready=1. On that handshake:
- if idx = NUM_LEDS-1, the block SHALL deassert pix_valid and go to LATCH with the gap counter at 0;
- otherwise, the block SHALL deassert pix_valid, increment idx, and go to FETCH.
REQ-011 LATCH SHALL hold latch=1 for exactly RESET_CYCLES cycles, then:
- pulse frame_done for one cycle;
- increment frame_count, wrapping 16'hFFFF -> 0;
- return to IDLE.
REQ-012 Buffer swap:
- frame_commit SHALL set a commit_pending flag; multiple commits before the swap coalesce into one.
- buf_sel SHALL toggle only on an IDLE->FETCH transition, when commit_pending=1 or frame_commit=1 in that same cycle.
- The swap SHALL clear commit_pending.
- buf_sel SHALL never change mid-frame.
REQ-013 Deasserting enable mid-frame SHALL NOT abort the frame: all NUM_LEDS pixels and the LATCH gap SHALL complete, then the block SHALL stay in IDLE.
REQ-014 mem_rd SHALL never be asserted outside FETCH, and pix_valid SHALL never be asserted outside PRESENT.
REQ-015 The minimum pixel period SHALL be 3 cycles (FETCH, WAIT, PRESENT) when pix_ready is held at 1.
REQ-016 latch and pix_valid SHALL never be high in the same cycle.
REQ-017 Counter widths SHALL be: idx of $clog2(NUM_LEDS) bits, and the gap counter of $clog2(RESET_CYCLES)+1 bits.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE, idx = 0, gap counter = 0, commit_pending = 0;
- mem_rd = 0, mem_addr = 0, pix_valid = 0, pix_data = 0;
- latch = 0, buf_sel = 0, busy = 0, frame_done = 0, frame_count = 0.
REQ-019 Reset asserted mid-frame SHALL discard the frame in progress; after rst_n returns high, the block SHALL begin at IDLE with buf_sel = 0.

Verification (NUM_LEDS=4, RESET_CYCLES=10, mem_rdata = 24'h0000 followed by the address)
REQ-020 Bench scenario: release reset, enable=1, pix_ready=1 -> mem_addr 0,1,2,3 read in order, and pix_data = 000000, 000001, 000002, 000003. latch is high for exactly 10 cycles, then frame_done pulses once and frame_count = 1.
REQ-021 Bench scenario: frame_commit pulsed twice during frame 1 -> buf_sel stays 0 until frame 1 ends. Frame 2 then reads addresses 4..7 with buf_sel = 1, and frame 3 (no further commit) also reads 4..7.
REQ-022 Bench scenario: pix_ready held 0 for 5 cycles while on pixel 2 -> pix_valid=1 and pix_data=000002 stay stable, and there is no mem_rd during the stall. The handshake completes on the first cycle pix_ready=1.
REQ-023 Bench scenario: enable dropped during pixel 1 -> pixels 1..3 and the 10-cycle latch still complete, frame_done pulses, and the block then stays in IDLE with no mem_rd.
REQ-024 Bench scenario: frame_commit asserted in the same cycle as IDLE->FETCH -> the swap happens on that frame, and commit_pending = 0 afterwards.
REQ-025 Bench scenario: rst_n driven low mid-PRESENT between clock edges -> pix_valid, busy, latch and frame_count are 0 before the next rising edge of clk.
